seq_det_prog: RTL
=================

# seq_det_prog

Parametrised, runtime-programmable serial pattern detector with Moore-style registered output. It replaces the fixed 4-bit "1001" detector with these additions:
- a PAT_W-bit pattern that can be reloaded at run time;
- an input-valid qualifier;
- selectable overlapping or non-overlapping detection;
- an optional saturating match counter.

It sits on a 1-bit serial stream, after the deserialiser front end, and feeds its match pulse to downstream control.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- RST_PAT, 4'b1001, pattern loaded by reset (PAT_W bits, MSB = first bit received)
- CNT_W, 8, match counter width (1..32)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in  in  1  serial data bit
- in_valid  in  1  in is sampled only when high
- pat_load  in  1  load pat_val as the new pattern
- pat_val  in  PAT_W  new pattern, MSB first
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cnt_clr  in  1  clear match_cnt
- out  out  1  one-cycle match pulse
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- **Registers:**
  - pat: PAT_W bits
  - hist: PAT_W-bit shift history
  - fill: 0..PAT_W, number of valid history bits
  - state
  - out
  - match_cnt
- **Reset:**
  - pat = RST_PAT, hist = 0, fill = 0, state = ST_FILL.
  - out = 0, match_cnt = 0.
- **Valid bit** (in_valid = 1, pat_load = 0):
  - hist_n = {hist[PAT_W-2:0], in}
  - fill_n = min(fill+1, PAT_W)
  - match = (fill_n == PAT_W) && (hist_n == pat)
- **States:**
  - ST_FILL (fill < PAT_W): when fill_n == PAT_W, go to ST_FULL.
  - ST_FULL: compare on every valid bit.
  - On match with overlap = 1: stay in ST_FULL and keep hist_n.
  - On match with overlap = 0: fill = 0, go to ST_FILL. hist still takes hist_n, but it is ignored until refilled.
- **in_valid = 0:** hist, fill and state hold.
- **pat_load = 1:**
  - pat = pat_val, fill = 0, state = ST_FILL.
  - Any in_valid bit in the same cycle is discarded. Load wins.
- **overlap:** sampled per valid bit. Changing it mid-stream affects only the next match decision.
- **With the default pattern and overlap = 1,** behaviour is bit-identical to the legacy 1001 detector, except for output latency (see Timing).

## Timing
- **out:**
  - Registered: out <= match at the edge that samples the last pattern bit.
  - It is high for exactly one cycle, then returns to 0 even if in_valid stays low.
  - Latency: 1 cycle from the final bit's sampling edge to out visible.
- **Back-to-back matches** (overlap = 1, self-overlapping pattern): out may be high on consecutive cycles.
- **match_cnt:**
  - Increments at the same edge out is set; visible together with out.
  - Saturates at 2^CNT_W-1.
  - cnt_clr clears it to 0 at the next edge.
  - cnt_clr and a match in the same cycle: clear wins, result 0.
- **rst mid-stream:** rst overrides all inputs in that cycle, and any pending match is lost.
- **Detection floor:** the first match is possible only after PAT_W valid bits following reset or pat_load.

## Configuration
- **SEQDET_MATCH_CNT_EN defined:** the match counter is built as described above.
- **SEQDET_MATCH_CNT_EN undefined:**
  - No counter flops; match_cnt is tied to 0.
  - cnt_clr is ignored.
  - Port list is unchanged.

## Structure
- **Package seq_det_pkg:**
  - typedef enum logic [0:0] {ST_FILL, ST_FULL} seq_det_state_t
  - localparam bounds: PAT_W_MIN = 2, PAT_W_MAX = 16
- **Sub-module seq_det_cnt:**
  - Parametrised CNT_W saturating counter with inc and clr (clr priority).
  - Instantiated only under SEQDET_MATCH_CNT_EN.
- **Top:** history/fill datapath, state register, compare, out register.

## Test plan
1. **Reset pattern, overlap = 1:** valid stream 1,0,0,1,0,0,1 -> out pulses 1 cycle after the 4th bit and 1 cycle after the 7th bit; match_cnt = 2.
2. **Same stream, overlap = 0:** -> out pulses only after the 4th bit; match_cnt = 1.
3. **Stalls:** stream 1,0,0,1 with in_valid low for 3 cycles between every bit -> single out pulse 1 cycle after the final valid bit; no pulse during stalls.
4. **Runtime load and load priority:**
   - pat_load with pat_val = 4'b1111 while in_valid = 1, in = 1 -> that bit is discarded.
   - Then 5 valid 1s -> out pulses after the 4th and 5th bits (overlap = 1).
   - A stream of 1001 after the reload gives no pulse.
5. **Saturation and clear:** CNT_W = 2, five matches -> match_cnt = 3. Then cnt_clr coinciding with a match -> match_cnt = 0.
6. **Reset mid-stream:** rst asserted after 1,0,0 with in = 1 in the same cycle -> out stays 0, fill = 0, pat = RST_PAT. A fresh 1,0,0,1 then matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and bounds for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {ST_FILL, ST_FULL} seq_det_state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_det_if.sv
// Stream, pattern-programming and match-report signals of seq_det_prog.
interface seq_det_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);

  logic             in;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_val;
  logic             overlap;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in, in_valid, pat_load, pat_val, overlap, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  in, in_valid, pat_load, pat_val, overlap, cnt_clr,
    output out, match_cnt
  );

endinterface

// File: rtl/seq_det_cnt.sv
// Saturating match counter; clear has priority over increment.
module seq_det_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Build option: define SEQDET_MATCH_CNT_EN to include the saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1001,
  parameter int             CNT_W   = 8
) (
  input logic      clk,
  input logic      rst,
  seq_det_if.slave bus
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_det_prog: PAT_W out of range");
  end

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_out;
  seq_det_state_t    r_state;

  logic [PAT_W-1:0]  w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_full_n;
  logic              w_match;
  seq_det_state_t    w_state_n;

  // A load in the same cycle as a valid bit discards the bit.
  assign w_hist_n = {r_hist[PAT_W-2:0], bus.in};
  assign w_fill_n = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 1'b1;
  assign w_full_n = (r_state == ST_FULL) || (w_fill_n == FILL_MAX);
  assign w_match  = bus.in_valid && !bus.pat_load && w_full_n && (w_hist_n == r_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (bus.pat_load) begin
      w_state_n = ST_FILL;
    end else if (bus.in_valid) begin
      if (w_match && !bus.overlap) begin
        w_state_n = ST_FILL;
      end else if (w_full_n) begin
        w_state_n = ST_FULL;
      end
    end
  end

  // Non-overlapping mode restarts the fill count so history is rebuilt from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= RST_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else begin
      r_out <= w_match;
      if (bus.pat_load) begin
        r_pat  <= bus.pat_val;
        r_fill <= '0;
      end else if (bus.in_valid) begin
        r_hist <= w_hist_n;
        r_fill <= (w_match && !bus.overlap) ? '0 : w_fill_n;
      end
    end
  end

  assign bus.out = r_out;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] w_cnt;

  seq_det_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_match),
    .i_clr (bus.cnt_clr),
    .o_cnt (w_cnt)
  );

  assign bus.match_cnt = w_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt    = '0;
`endif

endmodule
